// File: rtl/data_cache_ctrl.sv
// -----------------------------------------------------------------------------
// data_cache_ctrl
//
// Direct-mapped, write-through, no-write-allocate data cache that sits between
// the core's memory stage and main memory.
//
// Load hits are answered combinationally in the same cycle. Load misses refill
// the whole line over a ready-handshake memory port. Stores always write
// through to memory, and they update the cached copy only when the line is
// resident. While an access is outstanding, dstall freezes the pipeline. DONE
// then drops dstall for one cycle so that the request retires.
//
// Optional build macro: DCACHE_STATS_EN
//   When defined, HitCount/MissCount outputs count IDLE load hits and misses.
//
// Parameters
//   LINES      number of cache lines (power of two, >= 2)
//   WORDS      32-bit words per line (power of two, >= 2)
//
// Ports
//   clk        clock
//   reset      asynchronous active-low reset
//   MemtoRegM  load request from M stage
//   MemWriteM  store request from M stage (wins over MemtoRegM)
//   ALUOutM    byte address, bits [1:0] ignored
//   WriteDataM store data
//   ReadDataM  load data returned to the core
//   dstall     stall request to the hazard unit
//   MemAddr    word-aligned memory address
//   MemWD      memory write data
//   MemRE      memory read strobe
//   MemWE      memory write strobe
//   MemRD      memory read data, valid with MemReady
//   MemReady   memory completes the current transfer this cycle
//   HitCount   (DCACHE_STATS_EN) load hit counter
//   MissCount  (DCACHE_STATS_EN) load miss counter
// -----------------------------------------------------------------------------
module data_cache_ctrl #(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemtoRegM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        dstall,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWD,
    output logic        MemRE,
    output logic        MemWE,
    input  logic [31:0] MemRD,
    input  logic        MemReady
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] HitCount,
    output logic [31:0] MissCount
`endif
);

    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 30 - OFF_W - IDX_W;
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_WRITE,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [OFF_W-1:0]   r_cnt;
    logic [LINES-1:0]   r_valid;
    logic [TAG_W-1:0]   r_tag  [0:LINES-1];
    logic [31:0]        r_data [0:LINES*WORDS-1];

    // Address decomposition
    logic [OFF_W-1:0]   w_off;
    logic [IDX_W-1:0]   w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic               w_unused_bits;

    assign w_off = ALUOutM[OFF_W+1:2];
    assign w_idx = ALUOutM[IDX_W+OFF_W+1:OFF_W+2];
    assign w_tag = ALUOutM[31:IDX_W+OFF_W+2];
    assign w_unused_bits = &{1'b0, ALUOutM[1:0]};

    // Request decode: a simultaneous load+store is handled as a store.
    logic w_store;
    logic w_load;
    assign w_store = MemWriteM;
    assign w_load  = MemtoRegM & ~MemWriteM;

    logic        w_hit;
    logic [31:0] w_word;
    assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_word = r_data[{w_idx, w_off}];

    logic w_fill_last;
    assign w_fill_last = (r_cnt == LAST_WORD);

    // Array write enables. Gating with reset ensures that an asserted reset
    // aborts any in-flight write, even if it arrives at the same clock edge.
    logic w_fill_we;
    logic w_store_we;
    assign w_fill_we  = reset && (r_state == S_FILL) && MemReady;
    assign w_store_we = reset && (r_state == S_WRITE) && MemReady && w_hit;

    // -------------------------------------------------------------------------
    // Control FSM, valid bits, and optional statistics
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_valid   <= '0;
`ifdef DCACHE_STATS_EN
            HitCount  <= '0;
            MissCount <= '0;
`endif
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_store) begin
                        r_state <= S_WRITE;
                    end else if (w_load) begin
                        if (w_hit) begin
`ifdef DCACHE_STATS_EN
                            HitCount <= HitCount + 32'd1;
`endif
                        end else begin
                            // The old line is overwritten word by word during
                            // the fill, so it must stop looking valid now.
                            r_valid[w_idx] <= 1'b0;
                            r_cnt          <= '0;
                            r_state        <= S_FILL;
`ifdef DCACHE_STATS_EN
                            MissCount <= MissCount + 32'd1;
`endif
                        end
                    end
                end
                S_FILL: begin
                    if (MemReady) begin
                        r_cnt <= r_cnt + OFF_W'(1);
                        if (w_fill_last) begin
                            r_valid[w_idx] <= 1'b1;
                            r_state        <= S_DONE;
                        end
                    end
                end
                S_WRITE: begin
                    if (MemReady) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Data and tag arrays. These have no reset; the valid bits guard them.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_fill_we) begin
            r_data[{w_idx, r_cnt}] <= MemRD;
            if (w_fill_last) begin
                r_tag[w_idx] <= w_tag;
            end
        end else if (w_store_we) begin
            r_data[{w_idx, w_off}] <= WriteDataM;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. All outputs are forced to zero while reset is asserted.
    // -------------------------------------------------------------------------
    always_comb begin
        ReadDataM = 32'd0;
        dstall    = 1'b0;
        MemAddr   = 32'd0;
        MemWD     = 32'd0;
        MemRE     = 1'b0;
        MemWE     = 1'b0;
        if (reset) begin
            unique case (r_state)
                S_IDLE: begin
                    dstall = w_store || (w_load && !w_hit);
                    if (w_load && w_hit) begin
                        ReadDataM = w_word;
                    end
                end
                S_FILL: begin
                    dstall  = 1'b1;
                    MemRE   = 1'b1;
                    MemAddr = {w_tag, w_idx, r_cnt, 2'b00};
                end
                S_WRITE: begin
                    dstall  = 1'b1;
                    MemWE   = 1'b1;
                    MemAddr = {ALUOutM[31:2], 2'b00};
                    MemWD   = WriteDataM;
                end
                S_DONE: begin
                    // The line has just been refilled, so the load now hits.
                    if (w_load && w_hit) begin
                        ReadDataM = w_word;
                    end
                end
                default: begin
                    dstall = 1'b0;
                end
            endcase
        end
    end

endmodule
